// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage program counter.
// Redirect classes are numerically ordered by priority.
package pc_pkg;

    typedef enum logic [2:0] {
        CLS_SEQ    = 3'd0,
        CLS_JUMP   = 3'd1,
        CLS_BRANCH = 3'd2,
        CLS_ERET   = 3'd3,
        CLS_EXC    = 3'd4
    } redir_cls_e;

    localparam int          DEF_STEP         = 4;
    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0080;

endpackage

// File: rtl/pc_redirect_arbiter.sv
// Combinational redirect selection: picks the highest-priority
// new request, then weighs it against the held pending entry.
import pc_pkg::*;

module pc_redirect_arbiter #(
    parameter int               WIDTH      = 32,
    parameter int               STEP       = DEF_STEP,
    parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(DEF_EXC_VECTOR)
) (
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             eret,
    input  logic [WIDTH-1:0] epc,
    input  logic             exception,
    input  logic             pend_valid,
    input  logic [WIDTH-1:0] pend_target,
    input  redir_cls_e       pend_cls,
    output redir_cls_e       new_cls,
    output logic [WIDTH-1:0] new_target,
    output redir_cls_e       win_cls,
    output logic [WIDTH-1:0] win_target
);

    localparam logic [WIDTH-1:0] ALIGN_MASK = ~(WIDTH'(STEP) - WIDTH'(1));

    logic [WIDTH-1:0] raw_target;

    always_comb begin
        new_cls    = CLS_SEQ;
        raw_target = '0;
        if (exception) begin
            new_cls    = CLS_EXC;
            raw_target = EXC_VECTOR;
        end else if (eret) begin
            new_cls    = CLS_ERET;
            raw_target = epc;
        end else if (branch_taken) begin
            new_cls    = CLS_BRANCH;
            raw_target = branch_target;
        end else if (jump) begin
            new_cls    = CLS_JUMP;
            raw_target = jump_target;
        end
        new_target = raw_target & ALIGN_MASK;
    end

    // Pending entry wins only when strictly higher; ties go to the new input.
    always_comb begin
        win_cls    = new_cls;
        win_target = new_target;
        if (pend_valid && (pend_cls > new_cls)) begin
            win_cls    = pend_cls;
            win_target = pend_target;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch program counter: advances on I-cache hit, redirects by
// priority, and holds one redirect across a cache stall.
import pc_pkg::*;

module pc_unit #(
    parameter int               WIDTH        = 32,
    parameter int               STEP         = DEF_STEP,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(DEF_EXC_VECTOR)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hit,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             eret,
    input  logic             exception,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] pc_plus_step,
    output logic [WIDTH-1:0] epc_out,
    output logic             redirect_pending
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic             pend_valid_q, pend_valid_d;
    logic [WIDTH-1:0] pend_target_q, pend_target_d;
    redir_cls_e       pend_cls_q, pend_cls_d;

    redir_cls_e       new_cls, win_cls;
    logic [WIDTH-1:0] new_target, win_target;

    pc_redirect_arbiter #(
        .WIDTH      (WIDTH),
        .STEP       (STEP),
        .EXC_VECTOR (EXC_VECTOR)
    ) u_arb (
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .eret          (eret),
        .epc           (epc_q),
        .exception     (exception),
        .pend_valid    (pend_valid_q),
        .pend_target   (pend_target_q),
        .pend_cls      (pend_cls_q),
        .new_cls       (new_cls),
        .new_target    (new_target),
        .win_cls       (win_cls),
        .win_target    (win_target)
    );

    assign pc_plus_step = pc_q + WIDTH'(STEP);

    always_comb begin
        pc_d          = pc_q;
        epc_d         = epc_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        pend_cls_d    = pend_cls_q;
        if (exception) begin
            pc_d         = win_target;
            epc_d        = pc_q;
            pend_valid_d = 1'b0;
            pend_cls_d   = CLS_SEQ;
        end else if (hit) begin
            pc_d         = (win_cls != CLS_SEQ) ? win_target : pc_plus_step;
            pend_valid_d = 1'b0;
            pend_cls_d   = CLS_SEQ;
        end else if ((new_cls != CLS_SEQ) && (new_cls >= pend_cls_q)) begin
            // Stall: keep the stronger redirect until fetch can move again.
            pend_valid_d  = 1'b1;
            pend_target_d = new_target;
            pend_cls_d    = new_cls;
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_VECTOR;
            epc_q         <= '0;
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
            pend_cls_q    <= CLS_SEQ;
        end else begin
            pc_q          <= pc_d;
            epc_q         <= epc_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
            pend_cls_q    <= pend_cls_d;
        end
    end

    assign pc_out           = pc_q;
    assign epc_out          = epc_q;
    assign redirect_pending = pend_valid_q;

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit, successor to the fixed 32-bit PC register in the fetch stage. Holds the fetch PC and advances it by one instruction only when the instruction cache reports a hit. Selects between sequential, jump, branch, return-from-exception and exception targets by fixed priority. Remembers a redirect that arrives during a cache stall, so no control transfer is lost while fetch is frozen.

## Interface
Parameters:
- WIDTH, 32, PC / address width in bits (≥ 8).
- STEP, 4, sequential increment in bytes; power of two.
- RESET_VECTOR, 0, PC value after reset.
- EXC_VECTOR, 32'h0000_0080, exception handler entry (truncated to WIDTH).

Ports:
- clk  in  1  clock; all state updates on the falling edge (same edge as the rest of the fetch stage).
- rst_n  in  1  asynchronous, active-low reset.
- hit  in  1  I-cache hit; 1 = fetch may advance, 0 = stall.
- jump  in  1  unconditional jump request.
- jump_target  in  WIDTH  jump destination.
- branch_taken  in  1  resolved taken branch.
- branch_target  in  WIDTH  branch destination.
- eret  in  1  return from exception; destination is epc_out.
- exception  in  1  exception request.
- pc_out  out  WIDTH  current fetch PC (registered).
- pc_plus_step  out  WIDTH  pc_out + STEP mod 2^WIDTH (combinational).
- epc_out  out  WIDTH  saved exception PC (registered).
- redirect_pending  out  1  a stalled redirect is held (registered).

## Operation
- Redirect classes in descending priority: EXC, ERET, BRANCH, JUMP, then SEQ (no redirect).
- All targets have their low log2(STEP) bits forced to zero before use.
- Pending register: a valid bit, a WIDTH-bit target and a class field.
- At each falling edge, the candidate is the highest-priority request among the new inputs and the pending entry.
  - At equal class, the new input beats the pending entry.
- exception = 1, regardless of hit:
  - pc_out ← EXC_VECTOR.
  - epc_out ← current pc_out.
  - pending cleared.
- Otherwise, if hit = 1:
  - If the candidate is a redirect: pc_out ← its target and pending is cleared.
  - Otherwise: pc_out ← pc_plus_step.
- Otherwise (hit = 0):
  - pc_out holds.
  - If a new redirect is present and its class ≥ the pending class (or pending is empty): pending ← {1, target, class}.
  - If the new redirect has a lower class than pending: it is dropped.
- ERET target is sampled from epc_out at the moment the request is accepted or latched. A later exception overwrites epc_out, but the exception also clears pending, so no stale ERET can survive.
- Sequential increment wraps modulo 2^WIDTH; there is no overflow flag.
- Reset (async, any time, including during a stall with a redirect pending):
  - pc_out = RESET_VECTOR.
  - epc_out = 0.
  - redirect_pending = 0, pending class = SEQ.
  - Takes effect immediately; the first update follows the first falling edge after rst_n rises.

## Timing
- Latency:
  - A redirect with hit = 1 appears on pc_out right after the same falling edge.
  - A redirect with hit = 0 appears after the first falling edge on which hit = 1.
- redirect_pending rises after the latching edge and falls after the edge that consumes it.
- Exceptions have a fixed latency of one edge and are never delayed by a stall.
- pc_plus_step has combinational delay only from pc_out; there is no path from any input to any output.

## Structure
- Shared package pc_pkg holds:
  - The redirect-class encoding (3 bits, priority-ordered): SEQ = 0, JUMP = 1, BRANCH = 2, ERET = 3, EXC = 4.
  - Default STEP, RESET_VECTOR and EXC_VECTOR constants.
- Sub-module pc_redirect_arbiter: purely combinational. Takes the request bits, targets and pending entry; returns the winning class and the aligned target.
- The pc_unit top holds only the registers and the hit/exception update rules.

## Test plan
- Reset then hit = 1 for 3 edges → pc_out goes 0 → 4 → 8 → 12.
- pc_out = 0x100, hit = 0, branch_taken with target 0x200 → pc_out holds at 0x100 and redirect_pending = 1. Then jump to 0x300 with hit still 0 → pending is still 0x200. Then hit = 1 → pc_out = 0x200 and redirect_pending = 0.
- pc_out = 0x40, hit = 0, exception → pc_out = 0x80 and epc_out = 0x40 after one edge. Later eret with hit = 1 → pc_out = 0x40.
- pc_out = 0x10, hit = 1, jump to 0x500 and branch to 0x600 on the same edge → pc_out = 0x600. Separately, target 0x603 → pc_out = 0x600 (aligned).
- WIDTH = 8, pc_out = 0xFC, hit = 1 → pc_out = 0x00.
- Pending branch held while hit = 0, then rst_n pulsed low mid-cycle → pc_out = RESET_VECTOR and redirect_pending = 0 immediately. Then hit = 1 → sequential fetch from RESET_VECTOR.
